logic_unit_pipe: RTL and testbench

Parametrised, pipelined successor of the ALU logic unit. It accepts operand pairs on a valid/ready handshake and computes one of eight bitwise/shift operations. Results travel through a configurable-depth elastic pipeline to a valid/ready output with result flags. It sits between the ALU decode/operand mux and the ALU result mux, and stalls cleanly under downstream backpressure.

---
 rtl/logic_unit_pkg.sv | 15 +
 rtl/logic_pipe_stage.sv | 43 ++++
 rtl/logic_unit_pipe.sv | 78 +++++++
 tb/tb_logic_unit_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared opcode definitions for the pipelined ALU logic unit.
package logic_unit_pkg;

  localparam int FUN_W = 3;

  localparam logic [FUN_W-1:0] FUN_AND  = 3'b000;
  localparam logic [FUN_W-1:0] FUN_OR   = 3'b001;
  localparam logic [FUN_W-1:0] FUN_NAND = 3'b010;
  localparam logic [FUN_W-1:0] FUN_NOR  = 3'b011;
  localparam logic [FUN_W-1:0] FUN_XOR  = 3'b100;
  localparam logic [FUN_W-1:0] FUN_XNOR = 3'b101;
  localparam logic [FUN_W-1:0] FUN_SHL  = 3'b110;
  localparam logic [FUN_W-1:0] FUN_SHR  = 3'b111;

endpackage

// File: rtl/logic_pipe_stage.sv
// One elastic register stage: loads whenever it is empty or its entry leaves this cycle.
module logic_pipe_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  input  logic [DW-1:0] up_data,
  output logic          up_ready,
  output logic          dn_valid,
  output logic [DW-1:0] dn_data,
  input  logic          dn_ready
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  assign up_ready = !valid_q || dn_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (up_ready) begin
      valid_d = up_valid;
      // data only moves on a real transfer so a held output never glitches
      if (up_valid) data_d = up_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign dn_valid = valid_q;
  assign dn_data  = data_q;

endmodule

// File: rtl/logic_unit_pipe.sv
// Bitwise/shift logic unit feeding a PIPE_STAGES-deep elastic pipeline with
// a combinational ready chain (full throughput, no bubbles).
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int PIPE_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FUN_W-1:0] ALU_FUN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Logic_OUT,
  output logic             Logic_Flag,
  output logic             Zero_Flag,
  output logic             Busy
);

  localparam int SW = $clog2(WIDTH);

  logic [WIDTH-1:0] res;
  logic             oversh;
  logic [SW-1:0]    shamt;

  // WIDTH is a power of two, so any set bit at or above SW means B >= WIDTH
  assign oversh = |(B >> SW);
  assign shamt  = B[SW-1:0];

  always_comb begin
    res = '0;
    case (ALU_FUN)
      FUN_AND:  res = A & B;
      FUN_OR:   res = A | B;
      FUN_NAND: res = ~(A & B);
      FUN_NOR:  res = ~(A | B);
      FUN_XOR:  res = A ^ B;
      FUN_XNOR: res = ~(A ^ B);
      FUN_SHL:  res = oversh ? '0 : (A << shamt);
      FUN_SHR:  res = oversh ? '0 : (A >> shamt);
      default:  res = '0;
    endcase
  end

  // index 0 is the input side, index PIPE_STAGES the output side
  logic [PIPE_STAGES:0]            vld_pipe;
  logic [PIPE_STAGES:0]            rdy_pipe;
  logic [PIPE_STAGES:0][WIDTH-1:0] dat_pipe;

  assign vld_pipe[0]           = in_valid;
  assign dat_pipe[0]           = res;
  assign rdy_pipe[PIPE_STAGES] = out_ready;
  assign in_ready              = rdy_pipe[0];

  for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
    logic_pipe_stage #(.DW(WIDTH)) u_stage (
      .clk      (CLK),
      .rst_n    (RST),
      .up_valid (vld_pipe[i]),
      .up_data  (dat_pipe[i]),
      .up_ready (rdy_pipe[i]),
      .dn_valid (vld_pipe[i+1]),
      .dn_data  (dat_pipe[i+1]),
      .dn_ready (rdy_pipe[i+1])
    );
  end

  assign out_valid  = vld_pipe[PIPE_STAGES];
  assign Logic_OUT  = out_valid ? dat_pipe[PIPE_STAGES] : '0;
  assign Logic_Flag = out_valid;
  assign Zero_Flag  = out_valid && (dat_pipe[PIPE_STAGES] == '0);
  assign Busy       = |vld_pipe[PIPE_STAGES:1];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomised and directed bench for logic_unit_pipe against a queue-based model.
module tb_logic_unit_pipe;

  localparam int W = 8;
  localparam int P = 2;

  logic CLK = 1'b0, RST = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, Logic_Flag, Zero_Flag, Busy;
  logic [2:0]   ALU_FUN = '0;
  logic [W-1:0] A = '0, B = '0;
  logic [W-1:0] Logic_OUT;

  logic_unit_pipe #(.WIDTH(W), .PIPE_STAGES(P)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .ALU_FUN(ALU_FUN), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .Logic_OUT(Logic_OUT), .Logic_Flag(Logic_Flag), .Zero_Flag(Zero_Flag), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  // model: FIFO of results with the edge at which each was accepted
  typedef struct { logic [W-1:0] r; int t; } ent_t;
  ent_t q[$];
  int cyc = 0;
  int n_vec = 0, n_err = 0;

  logic         exp_ov, exp_zf, exp_ir, exp_busy;
  logic [W-1:0] exp_out;
  logic         act_ov, act_zf, act_lf, act_ir, act_busy;
  logic [W-1:0] act_out;

  function automatic logic [W-1:0] ref_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    logic [W-1:0] r;
    n = int'(b);
    case (f)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = ~(a & b);
      3'd3: r = ~(a | b);
      3'd4: r = a ^ b;
      3'd5: r = ~(a ^ b);
      3'd6: r = (n >= W) ? '0 : W'(a << n);
      default: r = (n >= W) ? '0 : W'(a >> n);
    endcase
    return r;
  endfunction

  // One clock: drive, sample mid-cycle, predict, then advance the model at the edge.
  // The head entry reaches the output once it has been in flight P-1 edges.
  task automatic tick(input logic v, input logic [2:0] f, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic o);
    logic acc, pop;
    in_valid = v; ALU_FUN = f; A = a; B = b; out_ready = o;
    @(negedge CLK);
    exp_ov   = (q.size() > 0) && (cyc >= q[0].t + P - 1);
    exp_out  = exp_ov ? q[0].r : '0;
    exp_zf   = exp_ov && (exp_out == '0);
    exp_ir   = (q.size() < P) || o;
    exp_busy = q.size() > 0;
    act_ov = out_valid; act_out = Logic_OUT; act_zf = Zero_Flag;
    act_lf = Logic_Flag; act_ir = in_ready; act_busy = Busy;
    acc = v && exp_ir;
    pop = exp_ov && o;
    @(posedge CLK); #1;
    cyc++;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back('{r: ref_op(f, a, b), t: cyc});
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() > 0; k++) tick(1'b0, 3'd0, '0, '0, 1'b1);
    tick(1'b0, 3'd0, '0, '0, 1'b1);
    n_vec++;
    if (act_busy !== 1'b0) begin
      n_err++; $display("FAIL drain_idle Busy got %b want 0", act_busy);
    end
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if ({out_valid, Logic_Flag, Zero_Flag, Busy, Logic_OUT} !== '0) begin
      n_err++; $display("FAIL reset_outputs got %h want 0", {out_valid, Logic_Flag, Zero_Flag, Busy, Logic_OUT});
    end
    @(posedge CLK); #1; RST = 1'b1;
    @(negedge CLK);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_basic();
    tick(1'b1, 3'b000, 8'hF0, 8'h3C, 1'b1);
    tick(1'b0, 3'd0, '0, '0, 1'b1);
    n_vec++;
    if (act_ov !== 1'b0) begin
      n_err++; $display("FAIL basic_early out_valid got %b want 0", act_ov);
    end
    tick(1'b0, 3'd0, '0, '0, 1'b1);
    n_vec++;
    if ({act_ov, act_lf, act_zf, act_out} !== {1'b1, 1'b1, 1'b0, 8'h30}) begin
      n_err++; $display("FAIL basic_and got %h want %h", {act_ov, act_lf, act_zf, act_out}, {1'b1, 1'b1, 1'b0, 8'h30});
    end
    drain();
  endtask

  // Four ops back-to-back, results expected on four consecutive cycles.
  task automatic run_stream(input string nm, input logic [2:0] fn[4], input logic [W-1:0] aa[4],
                            input logic [W-1:0] bb[4], input logic [W-1:0] want[4], input logic [3:0] wz);
    for (int k = 0; k < 7; k++) begin
      if (k < 4) tick(1'b1, fn[k], aa[k], bb[k], 1'b1);
      else       tick(1'b0, 3'd0, '0, '0, 1'b1);
      n_vec++;
      if ({act_ov, act_lf, act_zf, act_ir, act_busy, act_out} !== {exp_ov, exp_ov, exp_zf, exp_ir, exp_busy, exp_out}) begin
        n_err++; $display("FAIL %s_model k=%0d got %h want %h", nm, k,
          {act_ov, act_lf, act_zf, act_ir, act_busy, act_out}, {exp_ov, exp_ov, exp_zf, exp_ir, exp_busy, exp_out});
      end
      if (k >= 2 && k <= 5) begin
        n_vec++;
        if ({act_ov, act_zf, act_out} !== {1'b1, wz[k-2], want[k-2]}) begin
          n_err++; $display("FAIL %s_result k=%0d got %h want %h", nm, k, {act_ov, act_zf, act_out}, {1'b1, wz[k-2], want[k-2]});
        end
      end
      if (k < 4) begin
        n_vec++;
        if (act_ir !== 1'b1) begin
          n_err++; $display("FAIL %s_ready k=%0d got %b want 1", nm, k, act_ir);
        end
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    run_stream("b2b", '{3'd4, 3'd5, 3'd3, 3'd2}, '{8'hAA, 8'hAA, 8'h00, 8'hFF},
               '{8'hFF, 8'hFF, 8'h00, 8'hFF}, '{8'h55, 8'hAA, 8'hFF, 8'h00}, 4'b1000);
  endtask

  task automatic test_shifts();
    run_stream("shift", '{3'd6, 3'd7, 3'd6, 3'd7}, '{8'h81, 8'h81, 8'h81, 8'hFF},
               '{8'd1, 8'd7, 8'd9, 8'd8}, '{8'h02, 8'h01, 8'h00, 8'h00}, 4'b1100);
  endtask

  task automatic test_backpressure();
    logic [2:0]   fn[4]   = '{3'd0, 3'd1, 3'd4, 3'd7};
    logic [W-1:0] aa[4]   = '{8'hF0, 8'h0F, 8'h12, 8'h80};
    logic [W-1:0] bb[4]   = '{8'h3C, 8'hF0, 8'h34, 8'h03};
    logic [W-1:0] want[4] = '{8'h30, 8'hFF, 8'h26, 8'h10};
    int idx = 0, got = 0, j;
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, fn[idx], aa[idx], bb[idx], 1'b0);
      if (exp_ir) idx++;
      n_vec++;
      if ({act_ir, act_busy, act_ov, act_out} !== {exp_ir, exp_busy, exp_ov, exp_out}) begin
        n_err++; $display("FAIL bp_stall_model k=%0d got %h want %h", k, {act_ir, act_busy, act_ov, act_out}, {exp_ir, exp_busy, exp_ov, exp_out});
      end
      if (k >= 2) begin
        n_vec++;
        if ({act_ir, act_busy, act_ov, act_out} !== {1'b0, 1'b1, 1'b1, 8'h30}) begin
          n_err++; $display("FAIL bp_full_hold k=%0d got %h want %h", k, {act_ir, act_busy, act_ov, act_out}, {1'b0, 1'b1, 1'b1, 8'h30});
        end
      end
    end
    for (int k = 0; k < 20 && got < 4; k++) begin
      j = (idx < 4) ? idx : 0;
      tick(idx < 4, fn[j], aa[j], bb[j], 1'b1);
      if (idx < 4 && exp_ir) idx++;
      if (act_ov === 1'b1) begin
        n_vec++;
        if (act_out !== want[got]) begin
          n_err++; $display("FAIL bp_order n=%0d got %h want %h", got, act_out, want[got]);
        end
        got++;
      end
    end
    n_vec++;
    if (got !== 4) begin
      n_err++; $display("FAIL bp_delivered got %0d want 4", got);
    end
    drain();
  endtask

  task automatic test_full_stream();
    for (int k = 0; k < 2; k++) tick(1'b1, 3'($urandom), W'($urandom), W'($urandom), 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 3'($urandom), W'($urandom), W'($urandom), 1'b1);
      n_vec++;
      if ({act_ov, act_ir, act_busy, act_zf, act_out} !== {1'b1, 1'b1, 1'b1, exp_zf, exp_out}) begin
        n_err++; $display("FAIL full_stream k=%0d got %h want %h", k, {act_ov, act_ir, act_busy, act_zf, act_out}, {1'b1, 1'b1, 1'b1, exp_zf, exp_out});
      end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) tick(1'b1, 3'd1, W'($urandom) | 8'h01, W'($urandom), 1'b0);
    in_valid = 1'b0;
    #2; RST = 1'b0; #1;
    n_vec++;
    if ({out_valid, Logic_Flag, Zero_Flag, Busy, Logic_OUT} !== '0) begin
      n_err++; $display("FAIL rst_mid_async got %h want 0", {out_valid, Logic_Flag, Zero_Flag, Busy, Logic_OUT});
    end
    q.delete();
    @(posedge CLK); #1; RST = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, 3'd0, '0, '0, 1'b1);
      n_vec++;
      if ({act_ov, act_ir, act_busy, act_out} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
        n_err++; $display("FAIL rst_mid_stale k=%0d got %h want %h", k, {act_ov, act_ir, act_busy, act_out}, {1'b0, 1'b1, 1'b0, 8'h00});
      end
    end
  endtask

  task automatic test_random();
    logic v, o;
    logic [W-1:0] b;
    for (int k = 0; k < 400; k++) begin
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 3) != 0);
      b = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 9)) : W'($urandom);
      tick(v, 3'($urandom), W'($urandom), b, o);
      n_vec++;
      if ({act_ov, act_lf, act_zf, act_ir, act_busy, act_out} !== {exp_ov, exp_ov, exp_zf, exp_ir, exp_busy, exp_out}) begin
        n_err++; $display("FAIL random k=%0d got %h want %h", k,
          {act_ov, act_lf, act_zf, act_ir, act_busy, act_out}, {exp_ov, exp_ov, exp_zf, exp_ir, exp_busy, exp_out});
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_shifts();
    test_backpressure();
    test_full_stream();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
